fetch_ctrl: RTL and testbench

- Sequences instruction fetch for the core.
- Owns the PC register and drives the instruction memory address. The instruction memory has a combinational read, so data returns in the same cycle.
- Predecodes each fetched word and statically predicts JAL as taken.
- Buffers fetched words in a 2-entry queue with valid/ready toward decode. A redirect from execute flushes the queue and reloads the PC.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 48 ++++
 rtl/fetch_ctrl.sv | 65 ++++++
 tb/tb_fetch_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit: opcodes, the queued fetch entry
// and the JAL immediate decoder.
package fetch_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } fetch_entry_t;

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetch entries; flush wins over push and clears both slots.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot1;

  // The caller never pops an empty queue nor pushes a full one without popping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_entry;
          else               slot1 <= push_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= slot1;
          slot1 <= '0;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_entry;
          end else begin
            head  <= slot1;
            slot1 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, predecodes JAL as taken and feeds decode
// through a 2-entry queue; an execute redirect flushes and reloads the PC.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_pred_taken,
  output logic [XLEN-1:0] out_pred_pc
);

  logic [XLEN-1:0] pc_r;
  logic            is_jal;
  logic [XLEN-1:0] pred_pc;
  logic            pop;
  logic            fire;
  logic [1:0]      count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign imem_addr = pc_r;

  assign is_jal  = (imem_inst[6:0] == OPC_JAL);
  assign pred_pc = is_jal ? pc_r + j_imm(imem_inst) : pc_r + 32'd4;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign fire      = ~redirect_valid & ((count != 2'd2) | pop);

  assign push_entry = '{inst: imem_inst, pc: pc_r, pred_taken: is_jal, pred_pc: pred_pc};

  always_ff @(posedge clk) begin
    if (rst)                 pc_r <= RESET_PC;
    else if (redirect_valid) pc_r <= redirect_pc & ~32'd3;
    else if (fire)           pc_r <= pred_pc;
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (fire),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign out_inst       = head.inst;
  assign out_pc         = head.pc;
  assign out_pred_taken = head.pred_taken;
  assign out_pred_pc    = head.pred_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a queue-level reference model checked
// every cycle, plus directed scenarios with hand-computed literals.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic [31:0] out_pred_pc;

  logic [31:0] mem [0:63];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] pred;
  } m_entry_t;

  m_entry_t    m_q[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  // Instruction memory: 64 words, aliased on address bits [7:2].
  assign imem_inst = mem[imem_addr[7:2]];

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pred_taken (out_pred_taken),
    .out_pred_pc    (out_pred_pc)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the falling edge, then wait for the next one.
  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
  endtask

  // Reference model: advance by the rising edge just passed (inputs are still
  // the ones sampled there), then compare the visible state.
  always @(negedge clk) begin : model
    m_entry_t    e;
    logic [31:0] w;
    int          off;
    bit          pop_m;
    bit          fire_m;
    if (rst) begin
      m_pc = RESET_PC;
      m_q.delete();
    end else begin
      pop_m  = (m_q.size() > 0) && out_ready;
      fire_m = !redirect_valid && ((m_q.size() < 2) || pop_m);
      w      = mem[m_pc[7:2]];
      off    = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      e.inst  = w;
      e.pc    = m_pc;
      e.taken = (w[6:0] == 7'h6F);
      e.pred  = e.taken ? m_pc + 32'(off) : m_pc + 32'd4;
      if (pop_m) void'(m_q.pop_front());
      if (redirect_valid) begin
        m_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (fire_m) begin
        m_q.push_back(e);
        m_pc = e.pred;
      end
    end
    checkOutput("model_addr", imem_addr, m_pc);
    checkOutput("model_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      checkOutput("model_inst", out_inst, m_q[0].inst);
      checkOutput("model_pc", out_pc, m_q[0].pc);
      checkOutput("model_taken", {31'd0, out_pred_taken}, {31'd0, m_q[0].taken});
      checkOutput("model_pred", out_pred_pc, m_q[0].pred);
    end
  end

  initial begin
    logic [15:0] pat;
    pat = 16'hB38D;
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_inst", out_inst, 32'h0);
    checkOutput("rst_pc", out_pc, 32'h0);
    checkOutput("rst_pred", out_pred_pc, 32'h0);

    // Streaming NOPs with out_ready high
    applyStimulus(0, 0, 0, 1);
    checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("stream_pc0", out_pc, 32'h0);
    checkOutput("stream_addr1", imem_addr, 32'h4);
    applyStimulus(0, 0, 0, 1);
    checkOutput("stream_pc1", out_pc, 32'h4);
    applyStimulus(0, 0, 0, 1);
    checkOutput("stream_pc2", out_pc, 32'h8);
    checkOutput("stream_addr3", imem_addr, 32'hC);

    // Backpressure from reset release
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("bp_addr_hold", imem_addr, 32'h8);
    checkOutput("bp_head", out_pc, 32'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bp_pc1", out_pc, 32'h4);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bp_pc2", out_pc, 32'h8);
    checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);

    // JAL forward to 0x20 and back to 0x10
    mem[4] = 32'h0100_006F;
    mem[8] = 32'hFF1F_F06F;
    applyStimulus(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("jal_pc", out_pc, 32'h10);
    checkOutput("jal_taken", {31'd0, out_pred_taken}, 32'd1);
    checkOutput("jal_pred", out_pred_pc, 32'h20);
    checkOutput("jal_next_addr", imem_addr, 32'h20);
    applyStimulus(0, 0, 0, 1);
    checkOutput("jal_neg_pc", out_pc, 32'h20);
    checkOutput("jal_neg_pred", out_pred_pc, 32'h10);
    checkOutput("jal_neg_addr", imem_addr, 32'h10);

    // Irregular backpressure with a mid-stream redirect, model-checked
    for (int i = 0; i < 16; i++) begin
      if (i == 9) applyStimulus(0, 1, 32'h0000_0041, pat[i]);
      else        applyStimulus(0, 0, 0, pat[i]);
    end
    mem[4] = NOP;
    mem[8] = NOP;

    // Redirect while the queue is full
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0000_0103, 0);
    checkOutput("redir_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("redir_addr", imem_addr, 32'h100);
    applyStimulus(0, 0, 0, 1);
    checkOutput("redir_pc", out_pc, 32'h100);

    // Wrap-around past the top of the address space
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1);
    checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_addr1", imem_addr, 32'h0);
    checkOutput("wrap_pred", out_pred_pc, 32'h0);

    // Reset overrides a simultaneous redirect
    applyStimulus(1, 1, 32'h0000_0200, 1);
    checkOutput("rstredir_addr", imem_addr, RESET_PC);
    checkOutput("rstredir_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rstredir_pc", out_pc, RESET_PC);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
